// File: rtl/line_cmd_queue.sv
// Range-checked command FIFO feeding line_drawing_engine over rts/rtr handshakes.
// Optional build macro LINE_CMD_CLIP_EN: clamp out-of-frame coordinates instead of dropping.
module line_cmd_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          flush,
    input  logic [51:0]   in_op,
    input  logic          in_rts,
    output logic          in_rtr,
    output logic [51:0]   out_op,
    output logic          out_rts,
    input  logic          out_rtr,
    output logic [AW:0]   count,
    output logic [7:0]    drop_cnt,
    output logic          err
);

    localparam logic [AW:0]   FullCnt = DEPTH[AW:0];
    localparam logic [AW-1:0] PtrOne  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CntOne  = {{AW{1'b0}}, 1'b1};
    localparam logic [9:0]    HLim    = H_RES[9:0];
    localparam logic [9:0]    VLim    = V_RES[9:0];

    logic [51:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    drop_cnt_q;
    logic          err_q;

    logic [9:0]    x0, y0, x1, y1;
    logic          legal, in_xfc, out_xfc, do_write, reject;
    logic [51:0]   wr_op;

    assign x0 = in_op[51:42];
    assign y0 = in_op[41:32];
    assign x1 = in_op[31:22];
    assign y1 = in_op[21:12];

    assign legal   = (x0 < HLim) && (x1 < HLim) && (y0 < VLim) && (y1 < VLim);
    assign in_rtr  = (count_q != FullCnt) && !flush;
    assign out_rts = (count_q != '0);
    assign in_xfc  = in_rts && in_rtr;
    assign out_xfc = out_rts && out_rtr;
    assign reject  = in_xfc && !legal;

`ifdef LINE_CMD_CLIP_EN
    // Clamped commands are still queued; err/drop_cnt then count clamp events.
    assign wr_op = {(x0 < HLim) ? x0 : HLim - 10'd1,
                    (y0 < VLim) ? y0 : VLim - 10'd1,
                    (x1 < HLim) ? x1 : HLim - 10'd1,
                    (y1 < VLim) ? y1 : VLim - 10'd1,
                    in_op[11:0]};
    assign do_write = in_xfc;
`else
    assign wr_op    = in_op;
    assign do_write = in_xfc && legal;
`endif

    always_comb begin
        count_d = count_q;
        unique case ({do_write, out_xfc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= reject;
            if (reject && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            // A pop in the flush cycle is consumed simply by clearing the pointers.
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_write) wr_ptr_q <= wr_ptr_q + PtrOne;
                if (out_xfc)  rd_ptr_q <= rd_ptr_q + PtrOne;
                count_q <= count_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_op;
        end
    end

    assign out_op   = out_rts ? mem_q[rd_ptr_q] : 52'b0;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_line_cmd_queue.sv
// Scoreboard bench for line_cmd_queue: stimulus queues expected heads, a monitor checks pops.
module tb_line_cmd_queue;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        flush = 1'b0;
    logic [51:0] in_op = '0;
    logic        in_rts = 1'b0;
    logic        in_rtr;
    logic [51:0] out_op;
    logic        out_rts;
    logic        out_rtr = 1'b0;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;
    logic        err;

    int          total = 0;
    int          bad = 0;
    logic [51:0] exp_q[$];
    logic        exp_keep = 1'b0;
    logic [51:0] exp_val = '0;

    line_cmd_queue dut (
        .clk      (clk),
        .rst_     (rst_),
        .flush    (flush),
        .in_op    (in_op),
        .in_rts   (in_rts),
        .in_rtr   (in_rtr),
        .out_op   (out_op),
        .out_rts  (out_rts),
        .out_rtr  (out_rtr),
        .count    (count),
        .drop_cnt (drop_cnt),
        .err      (err)
    );

    always #20 clk = ~clk;

    function automatic logic [51:0] mk(input int x0, input int y0, input int x1, input int y1,
                                       input int c);
        logic [9:0]  a, b, d, e;
        logic [11:0] f;
        a = x0[9:0]; b = y0[9:0]; d = x1[9:0]; e = y1[9:0]; f = c[11:0];
        return {a, b, d, e, f};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [51:0] op, input logic rts, input logic keep,
                         input logic [51:0] ev);
        in_op    = op;
        in_rts   = rts;
        exp_keep = keep;
        exp_val  = ev;
    endtask

    // Monitor: inputs are stable at negedge, so this sees exactly the upcoming edge's transfers.
    always @(negedge clk) begin
        if (!rst_) begin
            if (out_rts && out_rtr) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got %0h expected none", out_op);
                end else begin
                    check("pop_data", {12'b0, out_op}, {12'b0, exp_q.pop_front()});
                end
            end
            if (in_rts && in_rtr && exp_keep) exp_q.push_back(exp_val);
        end
        if (flush || rst_) exp_q.delete();
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int err_seen;
        logic [51:0] op;

        // Reset values
        tick(); tick();
        check("rst_in_rtr", 64'(in_rtr), 64'd1);
        check("rst_out_rts", 64'(out_rts), 64'd0);
        check("rst_out_op", 64'(out_op), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst_ = 1'b0;
        tick();

        // Single push then pop, exact bit pattern
        op = mk(0, 0, 639, 479, 'hFFF);
        drive(op, 1'b1, 1'b1, op);
        check("empty_no_bypass", 64'(out_rts), 64'd0);
        tick();
        drive('0, 1'b0, 1'b0, '0);
        check("t1_rts", 64'(out_rts), 64'd1);
        check("t1_op", 64'(out_op), 64'h000009FDDFFFF);
        check("t1_count", 64'(count), 64'd1);
        out_rtr = 1'b1;
        tick();
        out_rtr = 1'b0;
        check("t1_count_after_pop", 64'(count), 64'd0);
        check("t1_rts_after_pop", 64'(out_rts), 64'd0);

        // Fill to full; the 9th is refused
        for (int i = 0; i < 9; i++) begin
            op = mk(i, i, i + 1, i + 2, i);
            drive(op, 1'b1, 1'b1, op);
            check("fill_in_rtr", 64'(in_rtr), (i < 8) ? 64'd1 : 64'd0);
            tick();
        end
        drive('0, 1'b0, 1'b0, '0);
        check("full_count", 64'(count), 64'd8);
        out_rtr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("drain_count", 64'(count), 64'(7 - k));
        end
        out_rtr = 1'b0;

        // Out-of-frame x1
`ifdef LINE_CMD_CLIP_EN
        drive(mk(0, 0, 640, 0, 1), 1'b1, 1'b1, mk(0, 0, 639, 0, 1));
`else
        drive(mk(0, 0, 640, 0, 1), 1'b1, 1'b0, '0);
`endif
        check("illegal_in_rtr", 64'(in_rtr), 64'd1);
        tick();
        drive('0, 1'b0, 1'b0, '0);
        check("illegal_err", 64'(err), 64'd1);
        check("illegal_drop", 64'(drop_cnt), 64'd1);
`ifdef LINE_CMD_CLIP_EN
        check("illegal_count", 64'(count), 64'd1);
`else
        check("illegal_count", 64'(count), 64'd0);
`endif
        out_rtr = 1'b1;
        tick();
        out_rtr = 1'b0;
        check("err_one_cycle", 64'(err), 64'd0);
        check("after_illegal_count", 64'(count), 64'd0);

        // Steady push+pop at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) begin
            op = mk(100 + i, 10, 20, 30 + i, 'hA00 + i);
            drive(op, 1'b1, 1'b1, op);
            tick();
        end
        out_rtr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op = mk(200 + i, 400, 5 * i, 479 - i, 'h123 + i);
            drive(op, 1'b1, 1'b1, op);
            tick();
            check("pushpop_count", 64'(count), 64'd4);
        end
        drive('0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) tick();
        out_rtr = 1'b0;
        check("pushpop_drained", 64'(count), 64'd0);

        // Flush with a pop in the same cycle
        for (int i = 0; i < 5; i++) begin
            op = mk(300, 300 - i, 1, 1, 'h555);
            drive(op, 1'b1, 1'b1, op);
            tick();
        end
        drive('0, 1'b0, 1'b0, '0);
        check("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        out_rtr = 1'b1;
        drive(mk(1, 1, 1, 1, 1), 1'b1, 1'b1, mk(1, 1, 1, 1, 1));
        #1;
        check("flush_in_rtr", 64'(in_rtr), 64'd0);
        tick();
        flush = 1'b0;
        out_rtr = 1'b0;
        drive('0, 1'b0, 1'b0, '0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_rts", 64'(out_rts), 64'd0);
        check("flush_drop_kept", 64'(drop_cnt), 64'd1);

        // Reset with entries held
        for (int i = 0; i < 3; i++) begin
            op = mk(i, 2, 3, 4, 'h0F0);
            drive(op, 1'b1, 1'b1, op);
            tick();
        end
        drive('0, 1'b0, 1'b0, '0);
        check("pre_rst_count", 64'(count), 64'd3);
        rst_ = 1'b1;
        tick();
        check("rst2_count", 64'(count), 64'd0);
        check("rst2_rts", 64'(out_rts), 64'd0);
        check("rst2_op", 64'(out_op), 64'd0);
        check("rst2_in_rtr", 64'(in_rtr), 64'd1);
        check("rst2_drop", 64'(drop_cnt), 64'd0);
        check("rst2_err", 64'(err), 64'd0);
        rst_ = 1'b0;
        tick();

        // 300 illegal commands: drop_cnt saturates, err pulses each time
        err_seen = 0;
        out_rtr = 1'b1;
        for (int i = 0; i < 300; i++) begin
`ifdef LINE_CMD_CLIP_EN
            drive(mk(700, 500, 0, 0, i), 1'b1, 1'b1, mk(639, 479, 0, 0, i));
`else
            drive(mk(700, 500, 0, 0, i), 1'b1, 1'b0, '0);
`endif
            tick();
            if (err) err_seen++;
        end
        drive('0, 1'b0, 1'b0, '0);
        tick();
        if (err) err_seen++;
        tick();
        out_rtr = 1'b0;
        check("sat_drop", 64'(drop_cnt), 64'd255);
        check("err_pulses", 64'(err_seen), 64'd300);
        check("final_count", 64'(count), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
